// File: rtl/pc_sequencer.sv
// Program-counter sequencer. Advances the fetch PC, redirects on a taken
// jump (capturing a link address and squashing FLUSH_CYCLES wrong-path
// slots), and supports stall and halt/resume. All outputs are registered.
module pc_sequencer #(
  parameter int ADDR_W       = 16,
  parameter int RESET_PC     = 0,
  parameter int INC          = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_taken,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              flush,
  output logic [ADDR_W-1:0] link_pc,
  output logic [1:0]        state
);

  // Encoding is visible on the state port: 00 INIT, 01 RUN, 10 FLUSH, 11 HALT.
  typedef enum logic [1:0] {
    S_INIT  = 2'b00,
    S_RUN   = 2'b01,
    S_FLUSH = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] PC_RST     = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INC);
  // The counter is loaded with FLUSH_CYCLES-1 on the redirect edge and the
  // exit happens on the edge where it reads zero, so FLUSH lasts exactly
  // FLUSH_CYCLES cycles.
  localparam logic [3:0]        FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      st;
  logic [3:0]  cnt;
  // A halt requested alongside (or during) a redirect is deferred until the
  // wrong-path slots have been squashed.
  logic        halt_pend;

  assign state = st;

  // Single sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_INIT;
      pc        <= PC_RST;
      pc_valid  <= 1'b0;
      flush     <= 1'b0;
      link_pc   <= '0;
      cnt       <= '0;
      halt_pend <= 1'b0;
    end else begin
      case (st)
        S_INIT: begin
          st       <= S_RUN;
          pc       <= PC_RST;
          pc_valid <= 1'b1;
        end

        S_RUN: begin
          if (jump_taken) begin
            pc        <= jump_target;
            link_pc   <= pc + PC_INC;
            pc_valid  <= 1'b0;
            flush     <= 1'b1;
            cnt       <= FLUSH_LOAD;
            halt_pend <= halt_req;
            st        <= S_FLUSH;
          end else if (halt_req) begin
            pc_valid <= 1'b0;
            st       <= S_HALT;
          end else if (!stall) begin
            // Natural wrap at ADDR_W bits, no overflow indication.
            pc <= pc + PC_INC;
          end
        end

        S_FLUSH: begin
          // jump_taken and stall are deliberately ignored in this state.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (halt_req) halt_pend <= 1'b1;
          end else begin
            flush     <= 1'b0;
            halt_pend <= 1'b0;
            if (halt_pend || halt_req) begin
              pc_valid <= 1'b0;
              st       <= S_HALT;
            end else begin
              pc_valid <= 1'b1;
              st       <= S_RUN;
            end
          end
        end

        S_HALT: begin
          // A concurrent halt_req keeps us halted; pc is not advanced on exit.
          if (resume && !halt_req) begin
            pc_valid <= 1'b1;
            st       <= S_RUN;
          end
        end

        default: st <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         jump_taken = 1'b0;
  logic [W-1:0] jump_target = '0;
  logic         stall = 1'b0;
  logic         halt_req = 1'b0;
  logic         resume = 1'b0;
  logic [W-1:0] pc;
  logic         pc_valid;
  logic         flush;
  logic [W-1:0] link_pc;
  logic [1:0]   state;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer #(.ADDR_W(W), .RESET_PC(0), .INC(1), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .jump_taken(jump_taken), .jump_target(jump_target),
    .stall(stall), .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_valid(pc_valid), .flush(flush), .link_pc(link_pc), .state(state)
  );

  // Clock generation
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it; inputs are driven here too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] e_pc, input logic e_v,
                            input logic e_fl, input logic [1:0] e_st);
    check({tag, ".pc"}, 32'(pc), 32'(e_pc));
    check({tag, ".valid"}, 32'(pc_valid), 32'(e_v));
    check({tag, ".flush"}, 32'(flush), 32'(e_fl));
    check({tag, ".state"}, 32'(state), 32'(e_st));
  endtask

  // Redirect from RUN and wait out the 2-cycle flush; ends in RUN at target.
  task automatic jump_to(input logic [W-1:0] tgt);
    jump_taken = 1'b1; jump_target = tgt;
    tick();
    jump_taken = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // Reset values while rst is held
    #12;
    expect_out("reset", 16'h0000, 1'b0, 1'b0, 2'b00);
    check("reset.link", 32'(link_pc), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. free run from reset
    tick(); expect_out("t1.c0", 16'd0, 1'b1, 1'b0, 2'b01);
    tick(); expect_out("t1.c1", 16'd1, 1'b1, 1'b0, 2'b01);
    tick(); expect_out("t1.c2", 16'd2, 1'b1, 1'b0, 2'b01);
    tick(); expect_out("t1.c3", 16'd3, 1'b1, 1'b0, 2'b01);
    tick(); tick();
    check("t2.pre", 32'(pc), 32'd5);

    // 2. redirect at pc=5
    jump_taken = 1'b1; jump_target = 16'h0040;
    tick(); expect_out("t2.f0", 16'h0040, 1'b0, 1'b1, 2'b10);
    check("t2.link", 32'(link_pc), 32'd6);
    // 3. wrong-path jump during FLUSH is ignored
    jump_target = 16'h0080;
    tick(); expect_out("t3.f1", 16'h0040, 1'b0, 1'b1, 2'b10);
    jump_taken = 1'b0;
    tick(); expect_out("t2.tgt", 16'h0040, 1'b1, 1'b0, 2'b01);
    check("t3.link", 32'(link_pc), 32'd6);
    tick(); expect_out("t2.tgt1", 16'h0041, 1'b1, 1'b0, 2'b01);

    // 5. halt at pc=7, resume
    jump_to(16'd7);
    expect_out("t5.at7", 16'd7, 1'b1, 1'b0, 2'b01);
    halt_req = 1'b1;
    tick(); expect_out("t5.halt", 16'd7, 1'b0, 1'b0, 2'b11);
    halt_req = 1'b0; jump_taken = 1'b1; jump_target = 16'h0099;
    tick(); expect_out("t5.hold", 16'd7, 1'b0, 1'b0, 2'b11);
    jump_taken = 1'b0; halt_req = 1'b1; resume = 1'b1;
    tick(); expect_out("t5.both", 16'd7, 1'b0, 1'b0, 2'b11);
    halt_req = 1'b0;
    tick(); expect_out("t5.resume", 16'd7, 1'b1, 1'b0, 2'b01);
    check("t5.link", 32'(link_pc), 32'h42);
    resume = 1'b0;
    tick(); expect_out("t5.next", 16'd8, 1'b1, 1'b0, 2'b01);

    // 4. stall at pc=9 for 3 cycles
    tick(); check("t4.pre", 32'(pc), 32'd9);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out($sformatf("t4.s%0d", i), 16'd9, 1'b1, 1'b0, 2'b01);
    end
    stall = 1'b0;
    tick(); expect_out("t4.adv", 16'd10, 1'b1, 1'b0, 2'b01);
    // stall together with a jump: redirect wins
    stall = 1'b1; jump_taken = 1'b1; jump_target = 16'h0020;
    tick(); expect_out("t4.sj", 16'h0020, 1'b0, 1'b1, 2'b10);
    check("t4.sj.link", 32'(link_pc), 32'd11);
    stall = 1'b0; jump_taken = 1'b0;
    // stall high during FLUSH must not extend it
    stall = 1'b1;
    tick(); tick();
    expect_out("t4.noext", 16'h0020, 1'b1, 1'b0, 2'b01);
    stall = 1'b0;

    // 5b. halt_req with jump: FLUSH then HALT at target
    halt_req = 1'b1; jump_taken = 1'b1; jump_target = 16'h0030;
    tick(); expect_out("t5b.f0", 16'h0030, 1'b0, 1'b1, 2'b10);
    check("t5b.link", 32'(link_pc), 32'h21);
    halt_req = 1'b0; jump_taken = 1'b0;
    tick(); expect_out("t5b.f1", 16'h0030, 1'b0, 1'b1, 2'b10);
    tick(); expect_out("t5b.halt", 16'h0030, 1'b0, 1'b0, 2'b11);
    resume = 1'b1;
    tick(); expect_out("t5b.run", 16'h0030, 1'b1, 1'b0, 2'b01);
    resume = 1'b0;

    // 6. wrap-around
    jump_to(16'hFFFE);
    expect_out("t6.fe", 16'hFFFE, 1'b1, 1'b0, 2'b01);
    tick(); expect_out("t6.ff", 16'hFFFF, 1'b1, 1'b0, 2'b01);
    tick(); expect_out("t6.wrap", 16'h0000, 1'b1, 1'b0, 2'b01);

    // async reset mid-FLUSH with a pending halt
    halt_req = 1'b1; jump_taken = 1'b1; jump_target = 16'h0050;
    tick(); expect_out("t6.f0", 16'h0050, 1'b0, 1'b1, 2'b10);
    halt_req = 1'b0; jump_taken = 1'b0;
    #2 rst = 1'b1;
    #1;
    expect_out("t6.rst", 16'h0000, 1'b0, 1'b0, 2'b00);
    check("t6.rst.link", 32'(link_pc), 32'h0);
    tick(); #1;
    rst = 1'b0;
    // pending halt must have been cleared by reset
    tick(); expect_out("t6.post0", 16'd0, 1'b1, 1'b0, 2'b01);
    tick(); tick();
    expect_out("t6.post2", 16'd2, 1'b1, 1'b0, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
